fft_delay_line: RTL and testbench

Parametrised complex-sample delay line for the R2SDF FFT accelerator's feedback paths. It replaces the fixed 16-deep shift stage. Depth is selectable at run time (1..MAX_DEPTH), so one instance serves every FFT size. Each entry carries a validity tag, a controlled drain flushes the line after input stops, and the block emits the butterfly phase bit that the paired stage consumes.

---
 rtl/fft_acc_pkg.sv | 26 ++
 rtl/cplx_ring_buf.sv | 79 +++++++
 rtl/fft_delay_line.sv | 133 +++++++++++++
 tb/tb_fft_delay_line.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fft_acc_pkg.sv
// -----------------------------------------------------------------------------
// fft_acc_pkg
// Shared types and defaults for the R2SDF FFT accelerator delay-line blocks.
//   state_e : delay-line control states (IDLE, RUN, DRAIN)
//   cplx_t  : complex sample {re, im} at the default component width
//   DEF_*   : default component width and ring depth
// -----------------------------------------------------------------------------
package fft_acc_pkg;

  localparam int DEF_DATA_W    = 24;
  localparam int DEF_MAX_DEPTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

  // Default-width complex sample; blocks built at other widths declare
  // their own struct of the same shape.
  typedef struct packed {
    logic signed [DEF_DATA_W-1:0] re;
    logic signed [DEF_DATA_W-1:0] im;
  } cplx_t;

endpackage

// File: rtl/cplx_ring_buf.sv
// -----------------------------------------------------------------------------
// cplx_ring_buf
// Tagged ring of MAX_DEPTH complex entries with a wrap-at-len pointer.
// The entry under the pointer is read combinationally and overwritten on
// a step, so a value written on step k is read back on step k+len.
//   clk, reset            : clock, synchronous active-high reset
//   step_i                : advance the ring this cycle
//   clr_ptr_i             : force the pointer back to 0 (end of drain)
//   len_i                 : active ring length, 1..MAX_DEPTH
//   tag_i, wr_re_i/_im_i  : entry written at the pointer on a step
//   rd_tag_o, rd_re_o/_im_o : entry currently under the pointer
//   wrap_o                : this step moves the pointer from len-1 to 0
// -----------------------------------------------------------------------------
module cplx_ring_buf #(
  parameter int DATA_W    = 24,
  parameter int MAX_DEPTH = 16,
  parameter int DEPTH_W   = $clog2(MAX_DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     step_i,
  input  logic                     clr_ptr_i,
  input  logic [DEPTH_W-1:0]       len_i,
  input  logic                     tag_i,
  input  logic signed [DATA_W-1:0] wr_re_i,
  input  logic signed [DATA_W-1:0] wr_im_i,
  output logic                     rd_tag_o,
  output logic signed [DATA_W-1:0] rd_re_o,
  output logic signed [DATA_W-1:0] rd_im_o,
  output logic                     wrap_o
);

  localparam int PTR_W = $clog2(MAX_DEPTH);

  typedef struct packed {
    logic                     tag;
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
  } entry_t;

  entry_t           mem_q [MAX_DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;

  assign wrap_o   = step_i && (DEPTH_W'(ptr_q) == len_i - DEPTH_W'(1));
  assign rd_tag_o = mem_q[ptr_q].tag;
  assign rd_re_o  = mem_q[ptr_q].re;
  assign rd_im_o  = mem_q[ptr_q].im;

  // NOTE: every variable written here gets its default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    ptr_d = ptr_q;
    if (step_i) begin
      ptr_d = wrap_o ? '0 : ptr_q + PTR_W'(1);
    end
    if (clr_ptr_i) begin
      ptr_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  // NOTE: the array is cleared on reset on purpose: IDLE requires every tag
  // to be 0 and dout to read 0, which rules out an unreset RAM here.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
      for (int i = 0; i < MAX_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      if (step_i) begin
        mem_q[ptr_q] <= '{tag: tag_i, re: wr_re_i, im: wr_im_i};
      end
    end
  end

endmodule

// File: rtl/fft_delay_line.sv
// -----------------------------------------------------------------------------
// fft_delay_line
// Run-time-length complex delay line for R2SDF feedback paths. A sample
// accepted on step k leaves on step k+len; a stall drains the line with
// tag-0 bubbles, and the butterfly phase bit flips every len steps.
//   clk, reset        : clock, synchronous active-high reset
//   in_valid          : din_r/din_i carry a real sample this cycle
//   depth_sel         : requested length, latched only when leaving IDLE
//   din_r, din_i      : signed input sample
//   dout_r, dout_i    : signed sample leaving the line
//   out_valid         : dout is real and the line steps this cycle
//   phase             : 0 for len steps, 1 for the next len, repeating
//   busy              : controller is not IDLE
//   cfg_err           : pulse when an illegal depth_sel is latched
// -----------------------------------------------------------------------------
module fft_delay_line
  import fft_acc_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_DEPTH = DEF_MAX_DEPTH,
  parameter int DEPTH_W   = $clog2(MAX_DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [DEPTH_W-1:0]       depth_sel,
  input  logic signed [DATA_W-1:0] din_r,
  input  logic signed [DATA_W-1:0] din_i,
  output logic signed [DATA_W-1:0] dout_r,
  output logic signed [DATA_W-1:0] dout_i,
  output logic                     out_valid,
  output logic                     phase,
  output logic                     busy,
  output logic                     cfg_err
);

  state_e             state_q, state_d;
  logic [DEPTH_W-1:0] len_q, len_d;
  logic [DEPTH_W-1:0] cnt_q, cnt_d;
  logic               phase_q, phase_d;

  logic               depth_ok;
  logic [DEPTH_W-1:0] sel_len;
  logic [DEPTH_W-1:0] ring_len;
  logic               step;
  logic               wrap;
  logic               clr_ptr;
  logic               rd_tag;

  assign depth_ok = (depth_sel != '0) && (depth_sel <= DEPTH_W'(MAX_DEPTH));
  assign sel_len  = depth_ok ? depth_sel : DEPTH_W'(MAX_DEPTH);

  // The first step out of IDLE already uses the length being latched.
  assign ring_len = (state_q == IDLE) ? sel_len : len_q;
  assign step     = in_valid | (state_q == DRAIN);

  cplx_ring_buf #(
    .DATA_W   (DATA_W),
    .MAX_DEPTH(MAX_DEPTH),
    .DEPTH_W  (DEPTH_W)
  ) u_ring (
    .clk      (clk),
    .reset    (reset),
    .step_i   (step),
    .clr_ptr_i(clr_ptr),
    .len_i    (ring_len),
    .tag_i    (in_valid),
    .wr_re_i  (in_valid ? din_r : '0),
    .wr_im_i  (in_valid ? din_i : '0),
    .rd_tag_o (rd_tag),
    .rd_re_o  (dout_r),
    .rd_im_o  (dout_i),
    .wrap_o   (wrap)
  );

  assign out_valid = step & rd_tag;
  assign busy      = (state_q != IDLE);
  assign phase     = phase_q;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    clr_ptr = 1'b0;
    cfg_err = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          len_d   = sel_len;
          cfg_err = ~depth_ok;
          state_d = RUN;
        end
      end
      RUN: begin
        if (!in_valid) begin
          cnt_d   = len_q;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        cnt_d = cnt_q - DEPTH_W'(1);
        // A new sample wins over the final drain step.
        if (in_valid) begin
          state_d = RUN;
        end else if (cnt_q == DEPTH_W'(1)) begin
          clr_ptr = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    phase_d = phase_q ^ wrap;
    if (clr_ptr) begin
      phase_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      len_q   <= DEPTH_W'(MAX_DEPTH);
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: tb/tb_fft_delay_line.sv
// -----------------------------------------------------------------------------
// tb_fft_delay_line
// Directed bench for fft_delay_line (DATA_W=24, MAX_DEPTH=16). Inputs change
// just after the falling edge; outputs are compared 1 time unit later.
// -----------------------------------------------------------------------------
module tb_fft_delay_line;

  localparam int DATA_W    = 24;
  localparam int MAX_DEPTH = 16;
  localparam int DEPTH_W   = $clog2(MAX_DEPTH) + 1;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     in_valid;
  logic [DEPTH_W-1:0]       depth_sel;
  logic signed [DATA_W-1:0] din_r, din_i;
  logic signed [DATA_W-1:0] dout_r, dout_i;
  logic                     out_valid, phase, busy, cfg_err;

  int tests_run    = 0;
  int tests_failed = 0;

  fft_delay_line #(
    .DATA_W   (DATA_W),
    .MAX_DEPTH(MAX_DEPTH),
    .DEPTH_W  (DEPTH_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .depth_sel(depth_sel),
    .din_r    (din_r),
    .din_i    (din_i),
    .dout_r   (dout_r),
    .dout_i   (dout_i),
    .out_valid(out_valid),
    .phase    (phase),
    .busy     (busy),
    .cfg_err  (cfg_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One cycle of stimulus: drive after the falling edge, settle, return.
  task automatic drive(input bit iv, input int v);
    @(negedge clk);
    in_valid = iv;
    din_r    = iv ? DATA_W'(v) : '0;
    din_i    = iv ? DATA_W'(-v) : '0;
    #1;
  endtask

  // Continuous stream of n samples (re = base+k, im = -(base+k)), then a
  // stall and a full drain back to IDLE. len is the delay the bench expects.
  task automatic run_stream(input string name, input int dsel, input int n,
                            input int base, input int len, input bit exp_err);
    logic signed [DATA_W-1:0] exp_v;
    bit                       exp_ph;
    depth_sel = DEPTH_W'(dsel);
    for (int k = 1; k <= n; k++) begin
      drive(1'b1, base + k);
      if (k == 1) begin
        tests_run++;
        if (cfg_err !== exp_err || busy !== 1'b0) begin
          tests_failed++;
          $display("FAIL %s start: cfg_err=%b busy=%b, expected cfg_err=%b busy=0",
                   name, cfg_err, busy, exp_err);
        end
      end else begin
        tests_run++;
        if (cfg_err !== 1'b0 || busy !== 1'b1) begin
          tests_failed++;
          $display("FAIL %s k=%0d: cfg_err=%b busy=%b, expected 0/1",
                   name, k, cfg_err, busy);
        end
      end
      tests_run++;
      if (out_valid !== (k > len)) begin
        tests_failed++;
        $display("FAIL %s k=%0d out_valid: got %b expected %b",
                 name, k, out_valid, k > len);
      end
      exp_ph = (((k - 1) / len) % 2) == 1;
      tests_run++;
      if (phase !== exp_ph) begin
        tests_failed++;
        $display("FAIL %s k=%0d phase: got %b expected %b", name, k, phase, exp_ph);
      end
      if (k > len) begin
        exp_v = DATA_W'(base + k - len);
        tests_run++;
        if (dout_r !== exp_v || dout_i !== -exp_v) begin
          tests_failed++;
          $display("FAIL %s k=%0d dout: got %0d/%0d expected %0d/%0d",
                   name, k, dout_r, dout_i, exp_v, -exp_v);
        end
      end
      // Past the latch, depth_sel must have no effect.
      if (k == 2) depth_sel = DEPTH_W'(3);
    end

    // Stall cycle: RUN -> DRAIN, nothing steps.
    drive(1'b0, 0);
    tests_run++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s stall: out_valid=%b busy=%b expected 0/1", name, out_valid, busy);
    end
    for (int j = 1; j <= len; j++) begin
      drive(1'b0, 0);
      exp_v = DATA_W'(base + n - len + j);
      tests_run++;
      if (out_valid !== 1'b1 || busy !== 1'b1 || dout_r !== exp_v || dout_i !== -exp_v) begin
        tests_failed++;
        $display("FAIL %s drain j=%0d: ov=%b busy=%b dout=%0d/%0d expected 1/1 %0d/%0d",
                 name, j, out_valid, busy, dout_r, dout_i, exp_v, -exp_v);
      end
    end
    drive(1'b0, 0);
    tests_run++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || phase !== 1'b0 || dout_r !== '0 || dout_i !== '0) begin
      tests_failed++;
      $display("FAIL %s idle: busy=%b ov=%b phase=%b dout=%0d/%0d expected all 0",
               name, busy, out_valid, phase, dout_r, dout_i);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    depth_sel = '0;
    din_r     = '0;
    din_i     = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    tests_run++;
    if (dout_r !== '0 || dout_i !== '0 || out_valid !== 1'b0 || phase !== 1'b0 ||
        busy !== 1'b0 || cfg_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset: dout=%0d/%0d ov=%b phase=%b busy=%b cfg_err=%b expected all 0",
               dout_r, dout_i, out_valid, phase, busy, cfg_err);
    end
  endtask

  task automatic test_len16();
    run_stream("len16", 16, 40, 0, 16, 1'b0);
  endtask

  task automatic test_drain_len4();
    run_stream("len4", 4, 8, 100, 4, 1'b0);
  endtask

  task automatic test_cfg_err();
    run_stream("cfg0", 0, 20, 300, 16, 1'b1);
    run_stream("cfg20", 20, 20, 400, 16, 1'b1);
  endtask

  // len = 2 with in_valid low for two cycles: the second drain step is
  // also the last one and coincides with a new sample.
  task automatic test_gap_len2();
    int gap_iv [12] = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 0, 0, 0};
    int gap_v  [12] = '{10, 11, 12, 0, 0, 13, 14, 15, 16, 0, 0, 0};
    int gap_ov [12] = '{0, 0, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1};
    int gap_do [12] = '{0, 0, 10, 0, 11, 12, 0, 13, 14, 0, 15, 16};
    int gap_ph [12] = '{0, 0, 1, 1, 1, 0, 0, 1, 1, 0, 0, 0};
    logic signed [DATA_W-1:0] exp_v;
    depth_sel = DEPTH_W'(2);
    for (int c = 0; c < 12; c++) begin
      drive(gap_iv[c] != 0, gap_v[c]);
      tests_run++;
      if (out_valid !== (gap_ov[c] != 0) || phase !== (gap_ph[c] != 0)) begin
        tests_failed++;
        $display("FAIL gap c=%0d: ov=%b phase=%b expected %0d/%0d",
                 c, out_valid, phase, gap_ov[c], gap_ph[c]);
      end
      if (gap_ov[c] != 0) begin
        exp_v = DATA_W'(gap_do[c]);
        tests_run++;
        if (dout_r !== exp_v || dout_i !== -exp_v) begin
          tests_failed++;
          $display("FAIL gap c=%0d dout: got %0d/%0d expected %0d/%0d",
                   c, dout_r, dout_i, exp_v, -exp_v);
        end
      end
    end
    drive(1'b0, 0);
    tests_run++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL gap end: busy=%b ov=%b expected 0/0", busy, out_valid);
    end
  endtask

  task automatic test_reset_mid_run();
    depth_sel = DEPTH_W'(8);
    for (int k = 1; k <= 5; k++) drive(1'b1, 900 + k);
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    din_r    = '0;
    din_i    = '0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    tests_run++;
    if (dout_r !== '0 || dout_i !== '0 || out_valid !== 1'b0 || phase !== 1'b0 ||
        busy !== 1'b0 || cfg_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid: dout=%0d/%0d ov=%b phase=%b busy=%b cfg_err=%b expected all 0",
               dout_r, dout_i, out_valid, phase, busy, cfg_err);
    end
    run_stream("post_rst", 8, 12, 1000, 8, 1'b0);
  endtask

  task automatic test_len1();
    run_stream("len1", 1, 6, -50, 1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_len16();
    test_drain_len4();
    test_cfg_err();
    test_gap_len2();
    test_reset_mid_run();
    test_len1();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
